// File: rtl/onehot_sel_seq_if.sv
// Request/response bundle between the layer controller (master) and the
// one-hot bank-select generator (slave).
interface onehot_sel_seq_if #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned N_OUT = 16
);
    logic             mode;
    logic [SEL_W-1:0] code;
    logic             code_valid;
    logic             start;
    logic [SEL_W-1:0] start_idx;
    logic [SEL_W-1:0] last_idx;
    logic             adv;
    logic [N_OUT-1:0] sel_onehot;
    logic             sel_valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output mode, code, code_valid, start, start_idx, last_idx, adv,
        input  sel_onehot, sel_valid, busy, done, err
    );

    modport slave (
        input  mode, code, code_valid, start, start_idx, last_idx, adv,
        output sel_onehot, sel_valid, busy, done, err
    );
endinterface

// File: rtl/onehot_sel_seq.sv
// Registered one-hot bank select: direct decode of a code, or a pointer sweep start..last.
// Define ONEHOT_SEL_ERR_EN to reject out-of-range/misordered requests with an err pulse.
module onehot_sel_seq #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned N_OUT = 16
) (
    input logic             clk,
    input logic             rst_n,
    onehot_sel_seq_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    localparam logic [SEL_W:0] NOutW = (SEL_W + 1)'(N_OUT);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_OUT-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_ok;
    logic [SEL_W-1:0] si_eff, li_eff, ptr_inc;

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return {1'b0, idx} < NOutW;
    endfunction

    function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(N_OUT - 1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef ONEHOT_SEL_ERR_EN
    logic err_q, err_d;

    assign start_ok = in_range(bus.start_idx) && in_range(bus.last_idx) &&
                      (bus.start_idx <= bus.last_idx);
    assign si_eff   = bus.start_idx;
    assign li_eff   = bus.last_idx;
    // Legal sweeps never pass last, so the increment cannot leave range.
    assign ptr_inc  = ptr_q + SEL_W'(1);
    assign bus.err  = err_q;
`else
    localparam bit               IsPow2  = (N_OUT & (N_OUT - 1)) == 0;
    localparam logic [SEL_W-1:0] IdxMask = IsPow2 ? SEL_W'(N_OUT - 1) : {SEL_W{1'b1}};

    // Unchecked build: power-of-two banks wrap modulo N_OUT, others trust the caller.
    assign start_ok = 1'b1;
    assign si_eff   = bus.start_idx & IdxMask;
    assign li_eff   = bus.last_idx & IdxMask;
    assign ptr_inc  = (ptr_q + SEL_W'(1)) & IdxMask;
    assign bus.err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef ONEHOT_SEL_ERR_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // mode arbitrates when start and code_valid arrive together.
                if (bus.mode && bus.start) begin
                    if (start_ok) begin
                        state_d = StSweep;
                        ptr_d   = si_eff;
                        last_d  = li_eff;
                        sel_d   = onehot(si_eff);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
`ifdef ONEHOT_SEL_ERR_EN
                        err_d = 1'b1;
`endif
                    end
                end else if (!bus.mode && bus.code_valid) begin
                    if (in_range(bus.code)) begin
                        sel_d   = onehot(bus.code);
                        valid_d = 1'b1;
                    end else begin
`ifdef ONEHOT_SEL_ERR_EN
                        err_d = 1'b1;
`endif
                    end
                end
            end
            StSweep: begin
                sel_d   = onehot(ptr_q);
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (bus.adv) begin
                    if (ptr_q == last_q) begin
                        state_d = StIdle;
                        sel_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_inc;
                        sel_d = onehot(ptr_inc);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            last_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ONEHOT_SEL_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ONEHOT_SEL_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.sel_onehot = sel_q;
    assign bus.sel_valid  = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_onehot_sel_seq.sv
// Bench for onehot_sel_seq: directed vector table, reset corner cases, then
// randomized traffic against a queue-based reference model.
module tb_onehot_sel_seq;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned N_OUT = 16;
`ifdef ONEHOT_SEL_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    onehot_sel_seq_if #(.SEL_W(SEL_W), .N_OUT(N_OUT)) bus ();
    onehot_sel_seq #(.SEL_W(SEL_W), .N_OUT(N_OUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef ONEHOT_SEL_ERR_EN
    onehot_sel_seq_if #(.SEL_W(4), .N_OUT(12)) bus12 ();
    onehot_sel_seq #(.SEL_W(4), .N_OUT(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));
`endif

    // Observation vector: {sel_onehot, sel_valid, busy, done, err}
    typedef logic [N_OUT+3:0] obs_t;

    typedef struct {
        logic             mode;
        logic [SEL_W-1:0] code;
        logic             cv;
        logic             st;
        logic [SEL_W-1:0] si;
        logic [SEL_W-1:0] li;
        logic             adv;
        logic [N_OUT-1:0] sel;
        logic             v;
        logic             b;
        logic             d;
    } vec_t;

    int checks = 0;
    int errors = 0;

    vec_t vecs[24];

    bit m_sweep;
    int m_q[$];

    function automatic obs_t observe();
        return {bus.sel_onehot, bus.sel_valid, bus.busy, bus.done, bus.err};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h ({sel,valid,busy,done,err})", name, act, req);
        end
    endtask

    task automatic drive(input logic mode, input logic [SEL_W-1:0] code, input logic cv,
                         input logic st, input logic [SEL_W-1:0] si,
                         input logic [SEL_W-1:0] li, input logic adv);
        bus.mode       = mode;
        bus.code       = code;
        bus.code_valid = cv;
        bus.start      = st;
        bus.start_idx  = si;
        bus.last_idx   = li;
        bus.adv        = adv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t exp_obs(input logic [N_OUT-1:0] sel, input logic v, input logic b,
                                     input logic d, input logic e);
        return {sel, v, b, d, e};
    endfunction

    // Reference: a sweep is the list of indices still to be visited; adv pops one.
    task automatic model_step(output obs_t exp);
        logic [N_OUT-1:0] sel;
        logic             v, b, d, e;
        int               s, l, i;
        bit               legal;
        sel = '0; v = 1'b0; b = 1'b0; d = 1'b0; e = 1'b0;
        if (!m_sweep) begin
            if (bus.mode && bus.start) begin
                s = int'(bus.start_idx);
                l = int'(bus.last_idx);
                legal = 1'b1;
                if (ErrEn) legal = (s < N_OUT) && (l < N_OUT) && (s <= l);
                if (!legal) begin
                    e = 1'b1;
                end else begin
                    s = s % N_OUT;
                    l = l % N_OUT;
                    m_q.delete();
                    i = s;
                    m_q.push_back(i);
                    while (i != l) begin
                        i = (i + 1) % N_OUT;
                        m_q.push_back(i);
                    end
                    m_sweep = 1'b1;
                end
            end else if (!bus.mode && bus.code_valid) begin
                if (int'(bus.code) < N_OUT) begin
                    sel[bus.code] = 1'b1;
                    v = 1'b1;
                end else begin
                    e = ErrEn;
                end
            end
        end else if (bus.adv) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_sweep = 1'b0;
                d = 1'b1;
            end
        end
        if (m_sweep) begin
            sel[m_q[0]] = 1'b1;
            v = 1'b1;
            b = 1'b1;
        end
        exp = exp_obs(sel, v, b, d, e);
    endtask

    initial begin
        obs_t exp;

        //            mode code  cv    st    si    li    adv   sel       v     b     d
        vecs[0]  = '{1'b0, 4'd5,  1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd15, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd7,  1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd0,  1'b0, 1'b1, 4'd3, 4'd6, 1'b0, 16'h0008, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0010, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'd2,  1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 16'h0020, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'd9,  1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0040, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 4'd0,  1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 16'h0200, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0200, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 4'd0,  1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 4'd3,  1'b1, 1'b1, 4'd1, 4'd4, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 4'd3,  1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

`ifdef ONEHOT_SEL_ERR_EN
        bus12.mode = 1'b0; bus12.code = '0; bus12.code_valid = 1'b0; bus12.start = 1'b0;
        bus12.start_idx = '0; bus12.last_idx = '0; bus12.adv = 1'b0;
`endif

        // Reset held with a live direct request must keep everything at zero.
        rst_n = 1'b0;
        drive(1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("reset_hold%0d", k), observe(), '0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].mode, vecs[i].code, vecs[i].cv, vecs[i].st, vecs[i].si, vecs[i].li,
                  vecs[i].adv);
            step();
            check($sformatf("vec%0d", i), observe(),
                  exp_obs(vecs[i].sel, vecs[i].v, vecs[i].b, vecs[i].d, 1'b0));
        end

        // Asynchronous reset in the middle of a sweep sitting at ptr=4.
        drive(1'b1, 4'd0, 1'b0, 1'b1, 4'd2, 4'd10, 1'b0);
        step();
        check("mid_start", observe(), exp_obs(16'h0004, 1'b1, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        step();
        step();
        check("mid_ptr4", observe(), exp_obs(16'h0010, 1'b1, 1'b1, 1'b0, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear", observe(), '0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("reset_no_done%0d", k), observe(), '0);
        end
        rst_n = 1'b1;
        drive(1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        step();
        check("restart", observe(), exp_obs(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        step();
        check("restart_done", observe(), exp_obs(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));

`ifdef ONEHOT_SEL_ERR_EN
        // Twelve-bank instance: illegal code and misordered sweep both pulse err only.
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        bus12.mode = 1'b0; bus12.code = 4'd13; bus12.code_valid = 1'b1;
        step();
        check("err_code", obs_t'({bus12.sel_onehot, bus12.sel_valid, bus12.busy, bus12.done,
              bus12.err}), obs_t'(16'h0001));
        bus12.code_valid = 1'b0; bus12.mode = 1'b1; bus12.start = 1'b1;
        bus12.start_idx = 4'd8; bus12.last_idx = 4'd2;
        step();
        check("err_order", obs_t'({bus12.sel_onehot, bus12.sel_valid, bus12.busy, bus12.done,
              bus12.err}), obs_t'(16'h0001));
        bus12.start = 1'b0; bus12.mode = 1'b0; bus12.code = 4'd11; bus12.code_valid = 1'b1;
        step();
        check("err_then_idle", obs_t'({bus12.sel_onehot, bus12.sel_valid, bus12.busy,
              bus12.done, bus12.err}), obs_t'({12'h800, 4'b1000}));
        bus12.code_valid = 1'b0;
`endif

        // Randomized traffic against the reference model from a clean reset.
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        m_sweep = 1'b0;
        m_q.delete();
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  SEL_W'($urandom_range(0, 15)), SEL_W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            @(posedge clk);
            model_step(exp);
            #1;
            check($sformatf("rand%0d", c), observe(), exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_sel_seq.md
# onehot_sel_seq

- Registered, parametrised one-hot bank-select generator for the accelerator datapath. It drives write/read enables for N_OUT PE buffers or weight banks.
- It has two modes:
  - **Direct:** decodes a code, one pulse per request.
  - **Sweep:** an internal pointer walks one-hot select from start_idx to last_idx, one step per advance.
- It sits between the layer controller and the bank array.
- It succeeds the fixed combinational 4-to-16 decoder.

## Interface
- SEL_W, 4, width of code/index inputs
- N_OUT, 16, number of select lines; legal range 2..2**SEL_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = direct, 1 = sweep; sampled only with code_valid/start in IDLE
- code  in  SEL_W  direct-mode index
- code_valid  in  1  direct-mode request strobe
- start  in  1  sweep start strobe
- start_idx  in  SEL_W  first sweep index
- last_idx  in  SEL_W  final sweep index, inclusive
- adv  in  1  advance sweep pointer
- sel_onehot  out  N_OUT  registered one-hot select, all-zero when idle
- sel_valid  out  1  sel_onehot is meaningful
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep finished
- err  out  1  one-cycle pulse, illegal request (see Configuration)

## Operation
- **States:** IDLE, SWEEP.
- **Reset value of every output:** 0. The pointer resets to 0.
- **IDLE, code_valid=1, mode=0:**
  - The next cycle has sel_onehot[code]=1 and sel_valid=1, for exactly one cycle.
  - Outputs return to zero afterwards unless a new request arrives.
  - Back-to-back requests give back-to-back one-hot pulses.
- **IDLE, start=1, mode=1:**
  - Latches start_idx and last_idx and sets ptr=start_idx.
  - Enters SWEEP.
- **start and code_valid both high in IDLE:** mode decides which one is honoured. mode=1 takes start; mode=0 takes code_valid.
- **SWEEP:**
  - sel_onehot = onehot(ptr), sel_valid=1 and busy=1 are held every cycle.
  - adv=1 with ptr≠last: ptr increments by 1 next cycle.
  - adv=1 with ptr==last: done pulses next cycle, state returns to IDLE, and outputs go to zero in that same cycle.
  - adv=0: the pointer holds indefinitely.
- **Ignored inputs in SWEEP:** start, code_valid, code and mode are ignored. Re-start is only possible from IDLE.
- **Illegal requests:** code ≥ N_OUT, start_idx ≥ N_OUT, last_idx ≥ N_OUT, or start_idx > last_idx.
  - No select is asserted and the state stays IDLE.
  - err behaviour is set under Configuration.
- **start_idx == last_idx:** a single-step sweep. The first adv ends it.
- **Invariant:** sel_onehot is never more than one-hot and never nonzero while sel_valid=0.

## Timing
- Direct latency: 1 cycle, code_valid at edge k → sel_valid high after edge k+1.
- Sweep: start at edge k → sel_onehot[start_idx] valid after edge k+1.
- Each adv sampled at edge m updates the select after edge m+1.
- done is asserted in the cycle where busy drops to 0.
- The earliest new start is that same cycle; it is sampled at the next edge.
- rst_n low at any point, including mid-sweep, clears all outputs and state immediately (asynchronously). No done is generated.
- Sustained throughput: one select change per cycle in both modes.

## Configuration
- Macro: ONEHOT_SEL_ERR_EN.
- **Defined:**
  - Range and ordering checks are compiled in.
  - Illegal requests pulse err for one cycle, aligned with where sel_valid would have risen.
- **Undefined:**
  - err is tied 0.
  - An out-of-range direct code gives an all-zero select with sel_valid=0.
  - Sweep start is not rejected. Indices are masked modulo N_OUT only when N_OUT is a power of two; otherwise the caller guarantees legality.

## Test plan
- **Reset:** hold rst_n=0 with code_valid=1 → all outputs 0. Release, then code=4'd5, mode=0 → next cycle sel_onehot=16'h0020, sel_valid=1, then 0.
- **Direct back-to-back:** codes 0,15,7 on consecutive cycles → sel_onehot 16'h0001, 16'h8000, 16'h0080 on consecutive cycles. No bubbles.
- **Sweep start_idx=3, last_idx=6, adv every other cycle:**
  - Select steps 0x0008→0x0010→0x0020→0x0040; each holds while adv=0.
  - done pulses once, then busy=0 and sel_onehot=0.
- **Sweep with start/code_valid pulsed mid-sweep:** ignored, no pointer disturbance. Single-step sweep (idx 9,9) → one adv gives done.
- **ERR_EN defined, N_OUT=12:** code=13, then start with start_idx=8, last_idx=2 → err pulses twice, no select, state IDLE.
- **Reset mid-sweep at ptr=4:** outputs clear asynchronously. No done. A fresh start works normally after release.
